// File: rtl/matvec_pkg.sv
// Shared widths, timing constants and the FSM state type for the matrix-vector feeder.
package matvec_pkg;
  localparam int DATA_W      = 14;
  localparam int ACC_W       = 28;
  localparam int GAP_CYCLES  = 4;
  localparam int MAC_LATENCY = 5;

  typedef enum logic [2:0] {
    LOAD_W,
    LOAD_X,
    CLR,
    GAP,
    ISSUE,
    DRAIN,
    OUT
  } state_t;
endpackage

// File: rtl/matvec_feeder_operand_bank.sv
// Register storage for the matrix W and vector x: one write port, combinational reads.
module operand_bank
  import matvec_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int KW   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic              clk,
  input  logic              we_w,
  input  logic              we_x,
  input  logic [RW-1:0]     wr_r,
  input  logic [KW-1:0]     wr_c,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RW-1:0]     rd_r,
  input  logic [KW-1:0]     rd_k,
  output logic [DATA_W-1:0] w_rd,
  output logic [DATA_W-1:0] x_rd
);
  logic [DATA_W-1:0] w_mem [ROWS][COLS];
  logic [DATA_W-1:0] x_mem [COLS];

  always_ff @(posedge clk) begin
    if (we_w) w_mem[wr_r][wr_c] <= wdata;
    if (we_x) x_mem[wr_c] <= wdata;
  end

  assign w_rd = w_mem[rd_r][rd_k];
  assign x_rd = x_mem[rd_k];
endmodule

// File: rtl/matvec_feeder.sv
// Loads W and x, then streams each row's operand pairs into an external MAC and
// hands out one saturated row result per pass of the row index.
module matvec_feeder
  import matvec_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic              mac_valid,
  output logic              mac_reset,
  input  logic [ACC_W-1:0]  mac_f,
  input  logic              mac_valid_out,
  output logic [ACC_W-1:0]  y_data,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              busy
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int KW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CW = $clog2(COLS + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t            state;
  logic [RW-1:0]     r, ld_r;
  logic [KW-1:0]     ld_c, rd_k;
  logic [CW-1:0]     iss_idx, pulse_cnt;
  logic [GW-1:0]     gap_cnt;
  logic [DATA_W-1:0] w_rd, x_rd;
  logic              loading, s_fire;

  assign loading   = (state == LOAD_W) || (state == LOAD_X);
  assign s_ready   = !reset && loading;
  assign busy      = !reset && !loading;
  assign mac_reset = reset || (state == CLR);
  assign s_fire    = s_valid && s_ready;

  // Operands are registered, so the bank is read one column ahead of the one on the bus.
  assign rd_k = (state == ISSUE && iss_idx < CW'(COLS)) ? iss_idx[KW-1:0] : '0;

  operand_bank #(.ROWS(ROWS), .COLS(COLS)) u_bank (
    .clk   (clk),
    .we_w  (s_fire && state == LOAD_W),
    .we_x  (s_fire && state == LOAD_X),
    .wr_r  (ld_r),
    .wr_c  (ld_c),
    .wdata (s_data),
    .rd_r  (r),
    .rd_k  (rd_k),
    .w_rd  (w_rd),
    .x_rd  (x_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD_W;
      r         <= '0;
      ld_r      <= '0;
      ld_c      <= '0;
      iss_idx   <= '0;
      pulse_cnt <= '0;
      gap_cnt   <= '0;
      mac_valid <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      y_valid   <= 1'b0;
      y_data    <= '0;
    end else begin
      unique case (state)
        LOAD_W: if (s_fire) begin
          if (ld_c == KW'(COLS - 1)) begin
            ld_c <= '0;
            if (ld_r == RW'(ROWS - 1)) begin
              ld_r  <= '0;
              state <= LOAD_X;
            end else begin
              ld_r <= ld_r + 1'b1;
            end
          end else begin
            ld_c <= ld_c + 1'b1;
          end
        end
        LOAD_X: if (s_fire) begin
          if (ld_c == KW'(COLS - 1)) begin
            ld_c  <= '0;
            r     <= '0;
            state <= CLR;
          end else begin
            ld_c <= ld_c + 1'b1;
          end
        end
        CLR: begin
          gap_cnt   <= '0;
          pulse_cnt <= '0;
          state     <= GAP;
        end
        GAP: if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          mac_valid <= 1'b1;
          mac_a     <= w_rd;
          mac_b     <= x_rd;
          iss_idx   <= CW'(1);
          state     <= ISSUE;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        ISSUE: begin
          // Results may start returning before the last operand is issued.
          if (mac_valid_out) pulse_cnt <= pulse_cnt + 1'b1;
          if (iss_idx == CW'(COLS)) begin
            mac_valid <= 1'b0;
            mac_a     <= '0;
            mac_b     <= '0;
            state     <= DRAIN;
          end else begin
            mac_a   <= w_rd;
            mac_b   <= x_rd;
            iss_idx <= iss_idx + 1'b1;
          end
        end
        DRAIN: if (mac_valid_out) begin
          if (pulse_cnt == CW'(COLS - 1)) begin
            y_data  <= mac_f;
            y_valid <= 1'b1;
            state   <= OUT;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        OUT: if (y_ready) begin
          y_valid <= 1'b0;
          if (r == RW'(ROWS - 1)) begin
            state <= LOAD_W;
          end else begin
            r     <= r + 1'b1;
            state <= CLR;
          end
        end
        default: state <= LOAD_W;
      endcase
    end
  end
endmodule
